// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: PC width, opcode constants, FSM state encoding.
// Optional feature macro FETCH_PERF_EN is consumed by fetch_unit.
package fetch_unit_pkg;

    localparam int unsigned PcW = 16;
    localparam logic [3:0] OpHlt = 4'hF;

    typedef enum logic [1:0] {
        StRun,
        StMiss,
        StDrain,
        StHalt
    } fetch_state_e;

    function automatic logic [PcW-1:0] pc_inc(input logic [PcW-1:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_unit_ifid.sv
// IF/ID pipeline latch plus a one-entry skid buffer for data returned during a stall.
module fetch_unit_ifid
    import fetch_unit_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           clear,
    input  logic [PcW-1:0] instr,
    input  logic [PcW-1:0] pc_plus2,
    input  logic           skid_push,
    input  logic           skid_clear,
    input  logic [PcW-1:0] skid_in,
    output logic           if_valid,
    output logic [PcW-1:0] if_instr,
    output logic [PcW-1:0] if_pc_plus2,
    output logic           skid_valid,
    output logic [PcW-1:0] skid_data
);

    logic           valid_q;
    logic [PcW-1:0] instr_q;
    logic [PcW-1:0] pc_plus2_q;
    logic           skid_valid_q;
    logic [PcW-1:0] skid_data_q;

    // Neither load nor clear means hold (stall).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            instr_q    <= '0;
            pc_plus2_q <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q    <= 1'b1;
            instr_q    <= instr;
            pc_plus2_q <= pc_plus2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else if (skid_clear) begin
            skid_valid_q <= 1'b0;
        end else if (skid_push) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= skid_in;
        end
    end

    assign if_valid    = valid_q;
    assign if_instr    = instr_q;
    assign if_pc_plus2 = pc_plus2_q;
    assign skid_valid  = skid_valid_q;
    assign skid_data   = skid_data_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, requests instructions, fills IF/ID, handles redirect/stall/HLT.
// Define FETCH_PERF_EN to add the fetch_cnt / flush_cnt performance counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PcW-1:0] ResetPc   = 16'h0000,
    parameter logic [3:0]     HltOpcode = OpHlt
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic           redirect,
    input  logic [PcW-1:0] redirect_pc,
    output logic           imem_req,
    output logic [PcW-1:0] imem_addr,
    input  logic           imem_rdy,
    input  logic [PcW-1:0] imem_data,
    output logic           if_valid,
    output logic [PcW-1:0] if_instr,
    output logic [PcW-1:0] if_pc_plus2,
    output logic           flush_ifid,
    output logic           halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]    fetch_cnt,
    output logic [15:0]    flush_cnt
`endif
);

    fetch_state_e   state_q, state_d;
    logic [PcW-1:0] pc_q, pc_d;
    logic [PcW-1:0] pend_pc_q, pend_pc_d;
    logic           flush_q;

    logic           ifid_load, ifid_clear, skid_push, skid_clear;
    logic           skid_valid;
    logic [PcW-1:0] skid_data;
    logic [PcW-1:0] load_instr, pc_plus2, target;
    logic           load_is_hlt;

    assign target      = redirect_pc & 16'hFFFE;
    assign pc_plus2    = pc_inc(pc_q);
    assign load_instr  = skid_valid ? skid_data : imem_data;
    assign load_is_hlt = (load_instr[15:12] == HltOpcode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        ifid_load  = 1'b0;
        ifid_clear = 1'b0;
        skid_push  = 1'b0;
        skid_clear = 1'b0;
        unique case (state_q)
            StRun: begin
                if (redirect) begin
                    pc_d       = target;
                    ifid_clear = 1'b1;
                end else if (!stall) begin
                    if (imem_rdy) begin
                        ifid_load = 1'b1;
                        pc_d      = pc_plus2;
                        if (load_is_hlt) state_d = StHalt;
                    end else begin
                        ifid_clear = 1'b1;
                        state_d    = StMiss;
                    end
                end
            end
            StMiss: begin
                if (redirect) begin
                    ifid_clear = 1'b1;
                    skid_clear = 1'b1;
                    // Request still in flight: keep addressing it until it returns.
                    if (!skid_valid && !imem_rdy) begin
                        pend_pc_d = target;
                        state_d   = StDrain;
                    end else begin
                        pc_d    = target;
                        state_d = StRun;
                    end
                end else if (skid_valid || imem_rdy) begin
                    if (!stall) begin
                        ifid_load  = 1'b1;
                        skid_clear = 1'b1;
                        pc_d       = pc_plus2;
                        state_d    = load_is_hlt ? StHalt : StRun;
                    end else if (!skid_valid) begin
                        skid_push = 1'b1;
                    end
                end else if (!stall) begin
                    ifid_clear = 1'b1;
                end
            end
            StDrain: begin
                if (redirect) ifid_clear = 1'b1;
                if (imem_rdy) begin
                    pc_d    = redirect ? target : pend_pc_q;
                    state_d = StRun;
                end else if (redirect) begin
                    pend_pc_d = target;
                end
            end
            StHalt: begin
                if (redirect) begin
                    pc_d       = target;
                    ifid_clear = 1'b1;
                    state_d    = StRun;
                end else if (!stall) begin
                    ifid_clear = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        unique case (state_q)
            StRun:   imem_req = ~stall;
            StMiss:  imem_req = ~skid_valid;
            StDrain: imem_req = 1'b1;
            StHalt:  imem_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= ResetPc;
            pend_pc_q <= ResetPc;
            flush_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            flush_q   <= redirect;
        end
    end

    assign imem_addr  = pc_q;
    assign flush_ifid = flush_q;
    assign halted     = (state_q == StHalt);

    fetch_unit_ifid u_ifid (
        .clk        (clk),
        .rst        (rst),
        .load       (ifid_load),
        .clear      (ifid_clear),
        .instr      (load_instr),
        .pc_plus2   (pc_plus2),
        .skid_push  (skid_push),
        .skid_clear (skid_clear),
        .skid_in    (imem_data),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc_plus2(if_pc_plus2),
        .skid_valid (skid_valid),
        .skid_data  (skid_data)
    );

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (state_q != StHalt) begin
            if (ifid_load) fetch_cnt_q <= fetch_cnt_q + 16'd1;
            if (redirect)  flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
